// File: rtl/msrv_32_wb_mux_sel_unit.sv
// -----------------------------------------------------------------------------
// msrv_32_wb_mux_sel_unit
//
// Write-back source selector and ALU second-operand selector for the MSRV32
// final pipeline stage.
//
// Ports:
//   ms_riscv32_mp_clk_in  in   1     rising-edge clock
//   ms_riscv32_mp_rst_in  in   1     synchronous, active-high reset
//   wb_mux_sel_reg_in     in   3     write-back source select
//   alu_result_in         in   XLEN  ALU result                (sel 000)
//   lu_output_in          in   XLEN  load-unit output          (sel 001)
//   imm_reg_in            in   XLEN  immediate / LUI value     (sel 010)
//   iadder_out_reg_in     in   XLEN  immediate-adder (AUIPC)   (sel 011)
//   csr_data_in           in   XLEN  CSR read data             (sel 100)
//   pc_plus_4_reg_in      in   XLEN  PC+4 link value           (sel 101)
//   rs2_reg_in            in   XLEN  rs2 register value
//   alu_src_reg_in        in   1     ALU operand-2 select: 1 = rs2, 0 = imm
//   wb_mux_out            out  XLEN  selected write-back data
//   alu_2nd_src_mux_out   out  XLEN  selected ALU second operand
//   wb_sel_err_out        out  1     sticky flag: reserved select code seen
//
// Build option:
//   MSRV32_WB_MUX_OUT_REG_EN  when defined, wb_mux_out is registered
//                             (1-cycle latency, synchronous reset to 0).
//                             Default build: wb_mux_out is combinational.
// -----------------------------------------------------------------------------
module msrv_32_wb_mux_sel_unit #(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [2:0]      wb_mux_sel_reg_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] lu_output_in,
  input  logic [XLEN-1:0] imm_reg_in,
  input  logic [XLEN-1:0] iadder_out_reg_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic [XLEN-1:0] pc_plus_4_reg_in,
  input  logic [XLEN-1:0] rs2_reg_in,
  input  logic            alu_src_reg_in,
  output logic [XLEN-1:0] wb_mux_out,
  output logic [XLEN-1:0] alu_2nd_src_mux_out,
  output logic            wb_sel_err_out
);

  typedef enum logic [2:0] {
    WB_ALU    = 3'b000,
    WB_LU     = 3'b001,
    WB_IMM    = 3'b010,
    WB_IADDER = 3'b011,
    WB_CSR    = 3'b100,
    WB_PC4    = 3'b101
  } wb_sel_e;

  logic [XLEN-1:0] w_wb_sel_data;
  logic            w_sel_reserved;
  logic            r_wb_sel_err;

  // Write-back source selection.
  always_comb begin
    // NOTE: assigning a default first, plus the default case arm, keeps this
    // block fully combinational -- any path that left w_wb_sel_data unassigned
    // would infer a latch.
    w_wb_sel_data = alu_result_in;
    case (wb_mux_sel_reg_in)
      WB_ALU:    w_wb_sel_data = alu_result_in;
      WB_LU:     w_wb_sel_data = lu_output_in;
      WB_IMM:    w_wb_sel_data = imm_reg_in;
      WB_IADDER: w_wb_sel_data = iadder_out_reg_in;
      WB_CSR:    w_wb_sel_data = csr_data_in;
      WB_PC4:    w_wb_sel_data = pc_plus_4_reg_in;
      default:   w_wb_sel_data = alu_result_in; // 110/111 reserved
    endcase
  end

  // Codes 110 and 111 are the only ones with the top two bits both set.
  assign w_sel_reserved = wb_mux_sel_reg_in[2] & wb_mux_sel_reg_in[1];

  // ALU second operand: independent of the write-back select and of reset.
  assign alu_2nd_src_mux_out = alu_src_reg_in ? rs2_reg_in : imm_reg_in;

  // Sticky reserved-code flag; reset wins over a same-edge reserved code.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (ms_riscv32_mp_rst_in) begin
      r_wb_sel_err <= 1'b0;
    end else if (w_sel_reserved) begin
      r_wb_sel_err <= 1'b1;
    end
  end

  assign wb_sel_err_out = r_wb_sel_err;

`ifdef MSRV32_WB_MUX_OUT_REG_EN
  logic [XLEN-1:0] r_wb_mux_out;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_wb_mux_out <= '0;
    end else begin
      r_wb_mux_out <= w_wb_sel_data;
    end
  end

  assign wb_mux_out = r_wb_mux_out;
`else
  assign wb_mux_out = w_wb_sel_data;
`endif

endmodule

// File: tb/tb_msrv_32_wb_mux_sel_unit.sv
// -----------------------------------------------------------------------------
// tb_msrv_32_wb_mux_sel_unit
//
// Directed self-checking bench for msrv_32_wb_mux_sel_unit. Inputs change on
// the falling edge; outputs are sampled 1 ns after a falling or rising edge.
// Expected wb_mux_out values follow the build: combinational by default,
// registered when MSRV32_WB_MUX_OUT_REG_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_msrv_32_wb_mux_sel_unit;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] ALU_V    = 32'h1234_5678;
  localparam logic [XLEN-1:0] LU_V     = 32'hABCD_EF01;
  localparam logic [XLEN-1:0] IMM_V    = 32'h8765_4321;
  localparam logic [XLEN-1:0] IADDER_V = 32'hDEAD_BEEF;
  localparam logic [XLEN-1:0] CSR_V    = 32'hFEED_FACE;
  localparam logic [XLEN-1:0] PC4_V    = 32'hBABE_CAFE;
  localparam logic [XLEN-1:0] RS2_V    = 32'hFEDC_BA98;

  logic            clk;
  logic            rst;
  logic [2:0]      sel;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] lu_output;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] iadder;
  logic [XLEN-1:0] csr_data;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] rs2;
  logic            alu_src;
  logic [XLEN-1:0] wb_mux_out;
  logic [XLEN-1:0] alu_2nd;
  logic            wb_sel_err;

  int tests_run    = 0;
  int tests_failed = 0;

  msrv_32_wb_mux_sel_unit #(.XLEN(XLEN)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .wb_mux_sel_reg_in    (sel),
    .alu_result_in        (alu_result),
    .lu_output_in         (lu_output),
    .imm_reg_in           (imm),
    .iadder_out_reg_in    (iadder),
    .csr_data_in          (csr_data),
    .pc_plus_4_reg_in     (pc_plus_4),
    .rs2_reg_in           (rs2),
    .alu_src_reg_in       (alu_src),
    .wb_mux_out           (wb_mux_out),
    .alu_2nd_src_mux_out  (alu_2nd),
    .wb_sel_err_out       (wb_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a select value and wait until the write-back output reflects it:
  // same cycle in the combinational build, after one edge when registered.
  task automatic apply_sel(input logic [2:0] s, input logic src);
    @(negedge clk);
    sel     = s;
    alu_src = src;
`ifdef MSRV32_WB_MUX_OUT_REG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] exp_wb;
    rst     = 1'b1;
    sel     = 3'b000;
    alu_src = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef MSRV32_WB_MUX_OUT_REG_EN
    exp_wb = '0;
`else
    exp_wb = ALU_V;
`endif
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: got %b expected 0", wb_sel_err);
    end
    tests_run++;
    if (wb_mux_out !== exp_wb) begin
      tests_failed++;
      $display("FAIL reset_wb: got %h expected %h", wb_mux_out, exp_wb);
    end
    tests_run++;
    if (alu_2nd !== IMM_V) begin
      tests_failed++;
      $display("FAIL reset_alu2: got %h expected %h", alu_2nd, IMM_V);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_sel(3'b000, 1'b0);
    tests_run++;
    if (wb_mux_out !== ALU_V) begin
      tests_failed++;
      $display("FAIL basic_wb: got %h expected %h", wb_mux_out, ALU_V);
    end
    tests_run++;
    if (alu_2nd !== IMM_V) begin
      tests_failed++;
      $display("FAIL basic_alu2: got %h expected %h", alu_2nd, IMM_V);
    end
  endtask

  task automatic test_link();
    apply_sel(3'b101, 1'b1);
    tests_run++;
    if (wb_mux_out !== PC4_V) begin
      tests_failed++;
      $display("FAIL link_wb: got %h expected %h", wb_mux_out, PC4_V);
    end
    tests_run++;
    if (alu_2nd !== RS2_V) begin
      tests_failed++;
      $display("FAIL link_alu2: got %h expected %h", alu_2nd, RS2_V);
    end
  endtask

  task automatic test_sweep();
    logic [2:0]      sels [4];
    logic [XLEN-1:0] exps [4];
    sels[0] = 3'b001; exps[0] = LU_V;
    sels[1] = 3'b010; exps[1] = IMM_V;
    sels[2] = 3'b011; exps[2] = IADDER_V;
    sels[3] = 3'b100; exps[3] = CSR_V;
    for (int i = 0; i < 4; i++) begin
      apply_sel(sels[i], 1'b0);
      tests_run++;
      if (wb_mux_out !== exps[i]) begin
        tests_failed++;
        $display("FAIL sweep_sel%b: got %h expected %h", sels[i], wb_mux_out, exps[i]);
      end
    end
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep_err: got %b expected 0", wb_sel_err);
    end
  endtask

  task automatic test_reserved(input logic [2:0] code);
    @(negedge clk);
    sel = code;
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsv%b_pre_edge_err: got %b expected 0", code, wb_sel_err);
    end
`ifndef MSRV32_WB_MUX_OUT_REG_EN
    tests_run++;
    if (wb_mux_out !== ALU_V) begin
      tests_failed++;
      $display("FAIL rsv%b_comb_wb: got %h expected %h", code, wb_mux_out, ALU_V);
    end
`endif
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsv%b_err_set: got %b expected 1", code, wb_sel_err);
    end
    tests_run++;
    if (wb_mux_out !== ALU_V) begin
      tests_failed++;
      $display("FAIL rsv%b_wb: got %h expected %h", code, wb_mux_out, ALU_V);
    end
    // Back to a legal code: the flag is sticky.
    @(negedge clk);
    sel = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsv%b_sticky: got %b expected 1", code, wb_sel_err);
    end
    // One reset edge clears it.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsv%b_cleared: got %b expected 0", code, wb_sel_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_priority();
    logic [XLEN-1:0] exp_wb;
`ifdef MSRV32_WB_MUX_OUT_REG_EN
    exp_wb = '0;
`else
    exp_wb = ALU_V;
`endif
    @(negedge clk);
    rst     = 1'b1;
    sel     = 3'b111;
    alu_src = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstprio_err: got %b expected 0", wb_sel_err);
    end
    tests_run++;
    if (wb_mux_out !== exp_wb) begin
      tests_failed++;
      $display("FAIL rstprio_wb: got %h expected %h", wb_mux_out, exp_wb);
    end
    tests_run++;
    if (alu_2nd !== RS2_V) begin
      tests_failed++;
      $display("FAIL rstprio_alu2: got %h expected %h", alu_2nd, RS2_V);
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 3'b000;
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstprio_after_err: got %b expected 0", wb_sel_err);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive select changes with the ALU operand toggling alongside.
    apply_sel(3'b011, 1'b1);
    tests_run++;
    if (wb_mux_out !== IADDER_V || alu_2nd !== RS2_V) begin
      tests_failed++;
      $display("FAIL b2b_0: got wb=%h alu2=%h expected wb=%h alu2=%h",
               wb_mux_out, alu_2nd, IADDER_V, RS2_V);
    end
    apply_sel(3'b100, 1'b0);
    tests_run++;
    if (wb_mux_out !== CSR_V || alu_2nd !== IMM_V) begin
      tests_failed++;
      $display("FAIL b2b_1: got wb=%h alu2=%h expected wb=%h alu2=%h",
               wb_mux_out, alu_2nd, CSR_V, IMM_V);
    end
  endtask

`ifdef MSRV32_WB_MUX_OUT_REG_EN
  task automatic test_registered();
    @(negedge clk);
    rst = 1'b1;
    sel = 3'b011;
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_mux_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reg_in_reset: got %h expected 00000000", wb_mux_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (wb_mux_out !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL reg_pre_edge: got %h expected 00000000", wb_mux_out);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (wb_mux_out !== IADDER_V) begin
      tests_failed++;
      $display("FAIL reg_post_edge: got %h expected %h", wb_mux_out, IADDER_V);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    sel        = 3'b000;
    alu_src    = 1'b0;
    alu_result = ALU_V;
    lu_output  = LU_V;
    imm        = IMM_V;
    iadder     = IADDER_V;
    csr_data   = CSR_V;
    pc_plus_4  = PC4_V;
    rs2        = RS2_V;

    test_reset();
    test_basic();
    test_link();
    test_sweep();
    test_reserved(3'b110);
    test_reserved(3'b111);
    test_reset_priority();
    test_back_to_back();
`ifdef MSRV32_WB_MUX_OUT_REG_EN
    test_registered();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/msrv_32_wb_mux_sel_unit.md
Name: msrv_32_wb_mux_sel_unit

Overview:
- Write-back source selector and ALU second-operand selector for the MSRV32 pipeline's final (WB/execute-boundary) stage.
- Picks one of six 32-bit result sources for the register-file write-back bus.
- Picks rs2 or the immediate as the ALU's second operand.
- Sits between the stage-3 pipeline registers, the ALU, the load unit and the CSR file, and the integer register file.

Parameters:
- XLEN, 32, datapath width of all data ports.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising-edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- wb_mux_sel_reg_in  input  3  write-back source select, registered by the upstream pipeline.
- alu_result_in  input  XLEN  ALU result.
- lu_output_in  input  XLEN  load-unit output.
- imm_reg_in  input  XLEN  immediate (LUI value / ALU operand).
- iadder_out_reg_in  input  XLEN  immediate-adder result (AUIPC).
- csr_data_in  input  XLEN  CSR read data.
- pc_plus_4_reg_in  input  XLEN  PC+4 (JAL/JALR link).
- rs2_reg_in  input  XLEN  rs2 register value.
- alu_src_reg_in  input  1  ALU operand-2 select: 1 = rs2, 0 = immediate.
- wb_mux_out  output  XLEN  selected write-back data.
- alu_2nd_src_mux_out  output  XLEN  selected ALU second operand.
- wb_sel_err_out  output  1  sticky flag, set when a reserved select code is seen.

Behaviour:
- Clock and reset: one clock, ms_riscv32_mp_clk_in; reset ms_riscv32_mp_rst_in is synchronous and active-high.
- Select encoding for wb_mux_sel_reg_in:
  - 000 alu_result_in
  - 001 lu_output_in
  - 010 imm_reg_in
  - 011 iadder_out_reg_in
  - 100 csr_data_in
  - 101 pc_plus_4_reg_in
  - 110 and 111 reserved; output alu_result_in (default arm, no latch).
- wb_mux_out: purely combinational in the default build; zero latency; follows any input change within the same cycle.
- alu_2nd_src_mux_out:
  - Purely combinational.
  - alu_src_reg_in = 1 -> rs2_reg_in; 0 -> imm_reg_in.
  - Independent of wb_mux_sel_reg_in and of reset.
- X/Z on a select input is not resolved by the design; the bench drives only known values.
- wb_sel_err_out:
  - Registered on each rising edge.
  - Reset has priority: when ms_riscv32_mp_rst_in = 1 at the edge, the flag goes to 0.
  - Otherwise it is set to 1 when wb_mux_sel_reg_in is 110 or 111 at the edge.
  - Once set, it holds until the next reset.
  - A reserved code asserted in the same cycle as reset leaves the flag at 0.
- Reset does not affect the combinational outputs.
- No handshake, no state machine, no arithmetic; all data paths are full XLEN width with no truncation or extension.

Optional Feature:
- Macro: MSRV32_WB_MUX_OUT_REG_EN.
- When defined:
  - wb_mux_out is driven from a flop that captures the combinational selection on each rising edge, giving 1-cycle latency.
  - The flop resets synchronously to 32'h0000_0000.
  - alu_2nd_src_mux_out stays combinational.
  - wb_sel_err_out behaviour is unchanged.
- When undefined: wb_mux_out is combinational as described in Behaviour.

Test Plan:
- Data inputs for all scenarios: alu=12345678, lu=abcdef01, imm=87654321, iadder=deadbeef, csr=feedface, pc4=babecafe, rs2=fedcba98.
- Basic selection: sel=000, alu_src=0 -> wb_mux_out=12345678, alu_2nd_src_mux_out=87654321.
- Link select: sel=101, alu_src=1 -> wb_mux_out=babecafe, alu_2nd_src_mux_out=fedcba98.
- Select sweep: sel=001/010/011/100 -> wb_mux_out = abcdef01 / 87654321 / deadbeef / feedface respectively.
- Reserved code: sel=110 -> wb_mux_out=12345678; after the next clock edge wb_sel_err_out=1; sel returns to 000 -> flag stays 1; assert reset for one edge -> flag=0.
- Reset priority: reset=1 with sel=111 on the same edge -> wb_sel_err_out=0, wb_mux_out still 12345678 (default build).
- Registered build (MSRV32_WB_MUX_OUT_REG_EN defined):
  - During reset, wb_mux_out=00000000.
  - Set sel=011 -> wb_mux_out=deadbeef only after the next rising edge.
